// File: rtl/ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_ctrl
// Purpose  : Turns PS/2 set-2 scan-code bytes into key events for the game.
//            It runs a make/break/extended prefix parser, skips the Pause
//            (E1) sequence and emits one pause make for it, and drops
//            typematic repeats. Events are buffered in a first-word-fall-
//            through FIFO with a valid/ready interface. Level flags are
//            held for left, right, fire and pause.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_ctrl #(
    parameter int DEPTH         = 8,          // event FIFO depth, power of two
    parameter int TIMEOUT       = 2_500_000,  // idle cycles before a prefix is abandoned
    parameter bit REPEAT_FILTER = 1'b1        // drop makes of the key already held
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       ev_valid,
    output logic [9:0] ev_data,
    input  logic       ev_ready,
    output logic       key_left,
    output logic       key_right,
    output logic       key_fire,
    output logic       key_pause,
    output logic       ovf,
    input  logic       ovf_clr
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DEPTH);

    // Parser states
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_EXT     = 3'd1;
    localparam logic [2:0] c_ST_BRK     = 3'd2;
    localparam logic [2:0] c_ST_EXT_BRK = 3'd3;
    localparam logic [2:0] c_ST_SKIP    = 3'd4;

    // Prefix and special bytes
    localparam logic [7:0] c_B_EXT    = 8'hE0;
    localparam logic [7:0] c_B_BRK    = 8'hF0;
    localparam logic [7:0] c_B_PAUSE  = 8'hE1;
    localparam logic [7:0] c_B_FSHIFT = 8'h12;

    // Pause sequence: E1 followed by seven more bytes
    localparam logic [2:0] c_SKIP_LEN = 3'd7;

    // Game keys as {ext, code}
    localparam logic [8:0] c_K_LEFT_EXT  = 9'h16B;
    localparam logic [8:0] c_K_LEFT_A    = 9'h01C;
    localparam logic [8:0] c_K_RIGHT_EXT = 9'h174;
    localparam logic [8:0] c_K_RIGHT_D   = 9'h023;
    localparam logic [8:0] c_K_FIRE      = 9'h029;
    localparam logic [8:0] c_K_PAUSE     = 9'h04D;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [2:0]         r_skip;
    logic [c_TMO_W-1:0] r_tmo;
    logic               w_tmo_hit;
    logic               w_junk;

    logic               w_emit;
    logic               w_brk;
    logic               w_ext;
    logic [7:0]         w_code;
    logic [9:0]         w_ev;

    logic [8:0]         r_held_code;
    logic               r_held_vld;
    logic               w_held_match;
    logic               w_filt;
    logic               w_push;

    logic [9:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr;
    logic [c_PTR_W-1:0] r_rd;
    logic [c_CNT_W-1:0] r_count;
    logic               w_pop;
    logic               w_full;
    logic               w_wr_ok;
    logic               w_ovf_set;
    logic               r_ovf;

    logic               r_left_a;
    logic               r_left_ext;
    logic               r_right_d;
    logic               r_right_ext;
    logic               r_fire;
    logic               r_pause;

    // ------------------------------------------------------------------------
    // Parser
    // ------------------------------------------------------------------------

    // Controller/keyboard status bytes that carry no key information
    assign w_junk = (byte_data == 8'h00) || (byte_data == 8'hAA) ||
                    (byte_data == 8'hEE) || (byte_data == 8'hFA) ||
                    (byte_data == 8'hFE) || (byte_data == 8'hFF);

    // A stalled prefix is abandoned on its last idle cycle; a byte arriving
    // in that same cycle takes priority.
    assign w_tmo_hit = (r_state != c_ST_IDLE) && !byte_valid && (r_tmo == c_TMO_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: prefix tracking and timeout abandonment
    always_comb begin
        w_state_nxt = r_state;
        if (byte_valid) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (byte_data == c_B_EXT) begin
                        w_state_nxt = c_ST_EXT;
                    end else if (byte_data == c_B_BRK) begin
                        w_state_nxt = c_ST_BRK;
                    end else if (byte_data == c_B_PAUSE) begin
                        w_state_nxt = c_ST_SKIP;
                    end
                end
                c_ST_EXT: begin
                    if (byte_data == c_B_BRK) begin
                        w_state_nxt = c_ST_EXT_BRK;
                    end else if (byte_data != c_B_EXT) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
                c_ST_BRK:     w_state_nxt = c_ST_IDLE;
                c_ST_EXT_BRK: w_state_nxt = c_ST_IDLE;
                c_ST_SKIP: begin
                    if (r_skip <= 3'd1) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
                default:      w_state_nxt = c_ST_IDLE;
            endcase
        end else if (w_tmo_hit) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    // Output logic: decide whether this byte completes an event
    always_comb begin
        w_emit = 1'b0;
        w_brk  = 1'b0;
        w_ext  = 1'b0;
        w_code = byte_data;
        if (byte_valid) begin
            case (r_state)
                c_ST_IDLE: begin
                    w_emit = !(w_junk || (byte_data == c_B_EXT) ||
                               (byte_data == c_B_BRK) || (byte_data == c_B_PAUSE));
                end
                c_ST_EXT: begin
                    w_ext  = 1'b1;
                    w_emit = (byte_data != c_B_BRK) && (byte_data != c_B_EXT) &&
                             (byte_data != c_B_FSHIFT);
                end
                c_ST_BRK: begin
                    w_brk  = 1'b1;
                    w_emit = 1'b1;
                end
                c_ST_EXT_BRK: begin
                    w_brk  = 1'b1;
                    w_ext  = 1'b1;
                    w_emit = (byte_data != c_B_FSHIFT);
                end
                c_ST_SKIP: begin
                    // The whole Pause sequence collapses to a single E1 make
                    w_code = c_B_PAUSE;
                    w_emit = (r_skip <= 3'd1);
                end
                default: w_emit = 1'b0;
            endcase
        end
    end

    assign w_ev = {w_brk, w_ext, w_code};

    // Pause-sequence byte counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skip <= '0;
        end else if (byte_valid && (r_state == c_ST_IDLE) && (byte_data == c_B_PAUSE)) begin
            r_skip <= c_SKIP_LEN;
        end else if (byte_valid && (r_state == c_ST_SKIP) && (r_skip != 3'd0)) begin
            r_skip <= r_skip - 3'd1;
        end else if (w_tmo_hit) begin
            r_skip <= '0;
        end
    end

    // Idle-cycle counter, only live while a prefix is pending
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (byte_valid || (r_state == c_ST_IDLE) || w_tmo_hit) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + c_TMO_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Typematic repeat filter
    // ------------------------------------------------------------------------
    assign w_held_match = (r_held_code == w_ev[8:0]);
    assign w_filt       = REPEAT_FILTER && w_emit && !w_brk && r_held_vld && w_held_match;
    assign w_push       = w_emit && !w_filt;

    // Remember the most recent make; its matching break releases it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_held_code <= '0;
            r_held_vld  <= 1'b0;
        end else if (w_emit && !w_brk) begin
            r_held_code <= w_ev[8:0];
            r_held_vld  <= 1'b1;
        end else if (w_emit && w_brk && w_held_match) begin
            r_held_vld  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Key level flags (track every emitted event, filtered or dropped)
    // ------------------------------------------------------------------------

    // Each alias has its own bit so releasing one does not drop the other
    always_ff @(posedge clk) begin
        if (rst) begin
            r_left_a    <= 1'b0;
            r_left_ext  <= 1'b0;
            r_right_d   <= 1'b0;
            r_right_ext <= 1'b0;
            r_fire      <= 1'b0;
            r_pause     <= 1'b0;
        end else if (w_emit) begin
            case (w_ev[8:0])
                c_K_LEFT_A:    r_left_a    <= !w_brk;
                c_K_LEFT_EXT:  r_left_ext  <= !w_brk;
                c_K_RIGHT_D:   r_right_d   <= !w_brk;
                c_K_RIGHT_EXT: r_right_ext <= !w_brk;
                c_K_FIRE:      r_fire      <= !w_brk;
                c_K_PAUSE:     r_pause     <= !w_brk;
                default: ;
            endcase
        end
    end

    assign key_left  = r_left_a  | r_left_ext;
    assign key_right = r_right_d | r_right_ext;
    assign key_fire  = r_fire;
    assign key_pause = r_pause;

    // ------------------------------------------------------------------------
    // Event FIFO (first-word-fall-through)
    // ------------------------------------------------------------------------
    assign ev_valid  = (r_count != '0);
    assign w_pop     = ev_valid && ev_ready;
    assign w_full    = (r_count == c_FULL);
    // A pop in the same cycle frees the slot for a push into a full FIFO
    assign w_wr_ok   = w_push && (!w_full || w_pop);
    assign w_ovf_set = w_push && w_full && !w_pop;
    assign ev_data   = ev_valid ? r_mem[r_rd] : 10'h000;

    // Storage array; no reset needed since entries are only read when valid
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr] <= w_ev;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr <= r_wr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + c_PTR_W'(1);
            end
            case ({w_wr_ok, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag; a new overflow wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_ctrl
// Purpose  : Self-checking bench for ps2_key_ctrl. A sequence-level model
//            (pending prefix bytes in a queue, events in a queue) predicts
//            every output each cycle, plus directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_ctrl;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic       ev_ready;
    logic       key_left;
    logic       key_right;
    logic       key_fire;
    logic       key_pause;
    logic       ovf;
    logic       ovf_clr;

    ps2_key_ctrl #(
        .DEPTH         (DEPTH),
        .TIMEOUT       (TIMEOUT),
        .REPEAT_FILTER (1'b1)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .ev_valid   (ev_valid),
        .ev_data    (ev_data),
        .ev_ready   (ev_ready),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_fire   (key_fire),
        .key_pause  (key_pause),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [9:0] mq[$];       // buffered events
    logic [7:0] pend[$];     // bytes of an unfinished sequence
    int         idle_cnt;
    bit         m_ovf;
    bit [8:0]   m_held;
    bit         m_held_vld;
    bit         m_la, m_lext, m_rd, m_rext, m_fire, m_pause;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        mq.delete();
        pend.delete();
        idle_cnt   = 0;
        m_ovf      = 0;
        m_held     = '0;
        m_held_vld = 0;
        {m_la, m_lext, m_rd, m_rext, m_fire, m_pause} = '0;
    endtask

    // Sequence interpretation: a byte either extends the pending sequence or
    // finishes it; the finished sequence's content decides brk/ext.
    task automatic m_byte(input logic [7:0] b, output bit em, output logic [9:0] ev);
        bit has_e0;
        bit has_f0;
        em = 0;
        ev = '0;
        if (pend.size() > 0 && pend[0] == 8'hE1) begin
            pend.push_back(b);
            if (pend.size() == 8) begin
                pend.delete();
                em = 1;
                ev = {2'b00, 8'hE1};
            end
            return;
        end
        has_e0 = 0;
        has_f0 = 0;
        foreach (pend[i]) begin
            if (pend[i] == 8'hE0) has_e0 = 1;
            if (pend[i] == 8'hF0) has_f0 = 1;
        end
        if (pend.size() == 0 && (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) return;
        if (pend.size() == 0 && b == 8'hE1) begin
            pend.push_back(b);
            return;
        end
        if ((b == 8'hE0 || b == 8'hF0) && !has_f0) begin
            pend.push_back(b);
            return;
        end
        pend.delete();
        if (has_e0 && b == 8'h12) return;
        em = 1;
        ev = {has_f0, has_e0, b};
    endtask

    task automatic check_all();
        chk("ev_valid",  ev_valid,  (mq.size() > 0));
        chk("ev_data",   ev_data,   (mq.size() > 0) ? mq[0] : 10'h000);
        chk("key_left",  key_left,  m_la | m_lext);
        chk("key_right", key_right, m_rd | m_rext);
        chk("key_fire",  key_fire,  m_fire);
        chk("key_pause", key_pause, m_pause);
        chk("ovf",       ovf,       m_ovf);
    endtask

    // One clock cycle: drive inputs, predict, clock, compare
    task automatic cyc(input bit bv, input logic [7:0] bd, input bit rdy, input bit clr);
        bit         em;
        bit         pop;
        bit         drop;
        bit         filt;
        logic [9:0] ev;
        byte_valid = bv;
        byte_data  = bd;
        ev_ready   = rdy;
        ovf_clr    = clr;
        pop  = (mq.size() > 0) && rdy;
        drop = 0;
        em   = 0;
        ev   = '0;
        if (bv) begin
            idle_cnt = 0;
            m_byte(bd, em, ev);
        end else begin
            idle_cnt++;
            if (idle_cnt >= TIMEOUT) pend.delete();
        end
        if (pop) void'(mq.pop_front());
        if (em) begin
            case (ev[8:0])
                9'h01C: m_la    = !ev[9];
                9'h16B: m_lext  = !ev[9];
                9'h023: m_rd    = !ev[9];
                9'h174: m_rext  = !ev[9];
                9'h029: m_fire  = !ev[9];
                9'h04D: m_pause = !ev[9];
                default: ;
            endcase
            filt = !ev[9] && m_held_vld && (m_held == ev[8:0]);
            if (!ev[9]) begin
                m_held     = ev[8:0];
                m_held_vld = 1;
            end else if (m_held == ev[8:0]) begin
                m_held_vld = 0;
            end
            if (!filt) begin
                if (mq.size() < DEPTH) mq.push_back(ev);
                else drop = 1;
            end
        end
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic b(input logic [7:0] v);
        cyc(1'b1, v, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        ev_ready   = 1'b0;
        ovf_clr    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_clear();
        chk("rst_ev_valid", ev_valid, 1'b0);
        chk("rst_ev_data",  ev_data,  10'h000);
        chk("rst_keys",     {key_left, key_right, key_fire, key_pause}, 4'b0000);
        chk("rst_ovf",      ovf,      1'b0);
    endtask

    logic [7:0] pool [16];

    initial begin
        pool = '{8'h1C, 8'h23, 8'h29, 8'h4D, 8'h6B, 8'h74, 8'h12, 8'hE0,
                 8'hE0, 8'hF0, 8'hF0, 8'hAA, 8'h00, 8'h15, 8'hE1, 8'hFF};
        m_clear();
        do_reset();

        // Typematic repeat filter
        b(8'h1C);
        chk("rep_first_data", ev_data, 10'h01C);
        chk("rep_left_set", key_left, 1'b1);
        b(8'h1C);
        b(8'h1C);
        b(8'hF0);
        chk("rep_left_held", key_left, 1'b1);
        b(8'h1C);
        chk("rep_left_clr", key_left, 1'b0);
        pop1();
        chk("rep_break_data", ev_data, 10'h21C);
        pop1();
        chk("rep_two_only", ev_valid, 1'b0);

        // Extended make/break
        do_reset();
        b(8'hE0);
        chk("ext_no_early", ev_valid, 1'b0);
        b(8'h74);
        chk("ext_make_valid", ev_valid, 1'b1);
        chk("ext_make_data", ev_data, 10'h174);
        chk("ext_right_set", key_right, 1'b1);
        pop1();
        b(8'hE0);
        b(8'hF0);
        chk("ext_right_held", key_right, 1'b1);
        b(8'h74);
        chk("ext_break_data", ev_data, 10'h374);
        chk("ext_right_clr", key_right, 1'b0);

        // Pause key sequence
        do_reset();
        b(8'hE1); b(8'h14); b(8'h77); b(8'hE1); b(8'hF0); b(8'h14); b(8'hF0);
        chk("pause_pending", ev_valid, 1'b0);
        b(8'h77);
        chk("pause_data", ev_data, 10'h0E1);
        chk("pause_flag", key_pause, 1'b0);
        pop1();
        b(8'h29);
        chk("pause_idle_after", ev_data, 10'h029);

        // Prefix timeout, and a gap just short of it
        do_reset();
        b(8'hE0);
        repeat (TIMEOUT + 2) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        b(8'h29);
        chk("tmo_data", ev_data, 10'h029);
        chk("tmo_fire", key_fire, 1'b1);
        pop1();
        b(8'hE0);
        repeat (TIMEOUT - 3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        b(8'h6B);
        chk("notmo_data", ev_data, 10'h16B);
        chk("notmo_left", key_left, 1'b1);

        // FIFO overflow
        do_reset();
        b(8'h1C); b(8'h23); b(8'h29); b(8'h4D); b(8'h6B); b(8'h74); b(8'h15); b(8'h16);
        chk("ovf_full_no_ovf", ovf, 1'b0);
        b(8'h1A);
        chk("ovf_set", ovf, 1'b1);
        chk("ovf_head", ev_data, 10'h01C);
        cyc(1'b1, 8'h1B, 1'b1, 1'b0);
        chk("ovf_pushpop_head", ev_data, 10'h023);
        chk("ovf_sticky", ovf, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_cleared", ovf, 1'b0);
        cyc(1'b1, 8'h1D, 1'b0, 1'b1);
        chk("ovf_set_beats_clr", ovf, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (7) pop1();
        chk("ovf_tenth_kept", ev_data, 10'h01B);
        pop1();
        chk("ovf_drained", ev_valid, 1'b0);

        // Reset in the middle of a sequence
        do_reset();
        b(8'h1C);
        b(8'hF0);
        do_reset();
        b(8'h1C);
        chk("midrst_make", ev_data, 10'h01C);
        chk("midrst_left", key_left, 1'b1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cyc(($urandom_range(0, 2) != 0), pool[$urandom_range(0, 15)],
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
